// File: rtl/cond_exec_stage.sv
// cond_exec_stage: ARM condition-evaluation stage behind the ALU.
// Evaluates the condition field against the architectural NZCV register,
// updates NZCV for executed flag-setting instructions, and queues the
// result in a 2-entry in-order buffer toward writeback.
// Optional build macro: COND_SKIP_DROP_EN -- instructions whose condition
// fails are consumed but never enter the buffer.
module cond_exec_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_flags,
    input  logic [3:0]       in_cond,
    input  logic             in_set_flags,
    input  logic             in_reg_write,
    input  logic [RADDR-1:0] in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RADDR-1:0] out_rd,
    output logic             out_reg_write,
    output logic             out_executed,
    output logic [3:0]       flags_q
);

    // Buffer storage, indexed by 1-bit head/tail pointers.
    logic [WIDTH-1:0] ent_result [2];
    logic [RADDR-1:0] ent_rd     [2];
    logic             ent_rw     [2];
    logic             ent_ex     [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;

    logic executed;
    logic accept;
    logic push;
    logic pop;

    // ARM condition table, evaluated on the NZCV value held before this
    // instruction's own flag update.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            default: cond_pass = 1'b1;   // AL and the 1111 encoding
        endcase
    endfunction

    assign executed = cond_pass(in_cond, flags_q);

    // Ready comes purely from registered occupancy, so no combinational
    // path exists from out_ready back to in_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef COND_SKIP_DROP_EN
    assign push = accept && executed;
`else
    assign push = accept;
`endif

    assign out_result    = ent_result[head];
    assign out_rd        = ent_rd[head];
    assign out_reg_write = ent_rw[head];
    assign out_executed  = ent_ex[head];

    // Buffer pointers, occupancy, entry storage and the NZCV register.
    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            flags_q <= 4'b0000;
            for (int i = 0; i < 2; i++) begin
                ent_result[i] <= '0;
                ent_rd[i]     <= '0;
                ent_rw[i]     <= 1'b0;
                ent_ex[i]     <= 1'b0;
            end
        end else begin
            if (push) begin
                ent_result[tail] <= in_result;
                ent_rd[tail]     <= in_rd;
                ent_rw[tail]     <= in_reg_write && executed;
                ent_ex[tail]     <= executed;
                tail             <= ~tail;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // A failed condition never touches NZCV, even with S set.
            if (accept && executed && in_set_flags)
                flags_q <= in_flags;
        end
    end

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: reset checks, a table of
// condition vectors, backpressure/reset sequences and a randomized run
// against a queue-based reference model.
module tb_cond_exec_stage;

`ifdef COND_SKIP_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic        in_reg_write;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_reg_write;
    logic        out_executed;
    logic [3:0]  flags_q;

    int n_checks = 0;
    int n_fail   = 0;

    cond_exec_stage #(.WIDTH(32), .RADDR(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_cond(in_cond),
        .in_set_flags(in_set_flags), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_executed(out_executed),
        .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  cond;
        logic        s;
        logic        rw;
        logic [3:0]  rd;
        logic        ex;      // expected condition outcome
        logic [3:0]  ef;      // expected flags_q afterwards
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  rd;
        logic        rw;
        logic        ex;
    } ent_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one instruction and advance one clock; sample 1 time unit later.
    task automatic cycle(input logic v, input logic [31:0] r, input logic [3:0] f,
                         input logic [3:0] c, input logic s, input logic rw,
                         input logic [3:0] rd, input logic ordy);
        in_valid = v; in_result = r; in_flags = f; in_cond = c;
        in_set_flags = s; in_reg_write = rw; in_rd = rd; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) cycle(1'b1, 32'hdead, 4'hf, 4'he, 1'b1, 1'b1, 4'hf, 1'b1);
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    // Reference condition test: pick the base predicate from cond[3:1] and
    // let cond[0] invert it; 111x always passes.
    function automatic bit m_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, base;
        n = f[3]; z = f[2]; cc = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = (n == v) && !z;
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    vec_t tbl [14];
    ent_t q [$];
    logic [3:0] mflags;

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_result = '0; in_flags = '0; in_cond = '0;
        in_set_flags = 1'b0; in_reg_write = 1'b0; in_rd = '0; out_ready = 1'b1;

        //           result flags    cond     s     rw    rd  ex    ef
        tbl[0]  = '{32'd4,  4'b0000, 4'b1110, 1'b1, 1'b1, 4'd3, 1'b1, 4'b0000}; // ADD 2+2
        tbl[1]  = '{32'd0,  4'b0110, 4'b1110, 1'b1, 1'b1, 4'd1, 1'b1, 4'b0110}; // SUB 2-2
        tbl[2]  = '{32'd7,  4'b0000, 4'b0000, 1'b0, 1'b1, 4'd2, 1'b1, 4'b0110}; // EQ
        tbl[3]  = '{32'd8,  4'b1000, 4'b0001, 1'b1, 1'b1, 4'd4, 1'b0, 4'b0110}; // NE, S ignored
        tbl[4]  = '{32'd9,  4'b0000, 4'b1110, 1'b0, 1'b1, 4'd5, 1'b1, 4'b0110}; // AL after NE
        tbl[5]  = '{32'd10, 4'b0000, 4'b1000, 1'b0, 1'b1, 4'd6, 1'b0, 4'b0110}; // HI
        tbl[6]  = '{32'd11, 4'b0000, 4'b1001, 1'b0, 1'b0, 4'd7, 1'b1, 4'b0110}; // LS, no write
        tbl[7]  = '{32'd12, 4'b1001, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0, 4'b0110}; // GT fails
        tbl[8]  = '{32'd13, 4'b1001, 4'b1010, 1'b1, 1'b1, 4'd9, 1'b1, 4'b1001}; // GE sets flags
        tbl[9]  = '{32'd14, 4'b0000, 4'b1011, 1'b1, 1'b1, 4'd10, 1'b0, 4'b1001}; // LT sees new flags
        tbl[10] = '{32'd15, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'd11, 1'b1, 4'b1001}; // MI
        tbl[11] = '{32'd16, 4'b0000, 4'b0010, 1'b0, 1'b1, 4'd12, 1'b0, 4'b1001}; // CS
        tbl[12] = '{32'd17, 4'b0000, 4'b0110, 1'b0, 1'b1, 4'd13, 1'b1, 4'b1001}; // VS
        tbl[13] = '{32'd18, 4'b0100, 4'b1111, 1'b1, 1'b1, 4'd14, 1'b1, 4'b0100}; // 1111 passes

        // Reset state.
        do_reset(2);
        check("reset_flags", flags_q, 4'b0000);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_result", out_result, 32'd0);

        // Table: one instruction per cycle with out_ready high, so the head
        // after each edge is the instruction just driven.
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, tbl[i].result, tbl[i].flags, tbl[i].cond, tbl[i].s,
                  tbl[i].rw, tbl[i].rd, 1'b1);
            check($sformatf("vec%0d_flags", i), flags_q, tbl[i].ef);
            check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            check($sformatf("vec%0d_out_valid", i), out_valid, DROP ? tbl[i].ex : 1'b1);
            if (!DROP || tbl[i].ex) begin
                check($sformatf("vec%0d_result", i), out_result, tbl[i].result);
                check($sformatf("vec%0d_rd", i), out_rd, tbl[i].rd);
                check($sformatf("vec%0d_reg_write", i), out_reg_write, tbl[i].rw & tbl[i].ex);
                check($sformatf("vec%0d_executed", i), out_executed, tbl[i].ex);
            end
        end
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
        check("drain_out_valid", out_valid, 1'b0);

        // Backpressure: 10 and 11 fill the buffer, 12 is held off.
        cycle(1'b1, 32'd10, 4'b0, 4'b1110, 1'b0, 1'b1, 4'd1, 1'b0);
        check("bp_in_ready_1", in_ready, 1'b1);
        cycle(1'b1, 32'd11, 4'b0, 4'b1110, 1'b0, 1'b1, 4'd2, 1'b0);
        check("bp_in_ready_full", in_ready, 1'b0);
        cycle(1'b1, 32'd12, 4'b0, 4'b1110, 1'b0, 1'b1, 4'd3, 1'b0);
        check("bp_still_full", in_ready, 1'b0);
        check("bp_head_stable", out_result, 32'd10);
        check("bp_valid_held", out_valid, 1'b1);
        cycle(1'b1, 32'd12, 4'b0, 4'b1110, 1'b0, 1'b1, 4'd3, 1'b1);
        check("bp_out_11", out_result, 32'd11);
        check("bp_ready_again", in_ready, 1'b1);
        cycle(1'b1, 32'd12, 4'b0, 4'b1110, 1'b0, 1'b1, 4'd3, 1'b1);
        check("bp_out_12", out_result, 32'd12);
        check("bp_rd_12", out_rd, 4'd3);
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
        check("bp_empty", out_valid, 1'b0);

        // Reset with two entries buffered discards them and clears flags.
        cycle(1'b1, 32'd20, 4'b1111, 4'b1110, 1'b1, 1'b1, 4'd1, 1'b0);
        cycle(1'b1, 32'd21, 4'b0000, 4'b1110, 1'b0, 1'b1, 4'd2, 1'b0);
        check("pre_reset_full", in_ready, 1'b0);
        check("pre_reset_flags", flags_q, 4'b1111);
        do_reset(1);
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_in_ready", in_ready, 1'b1);
        check("midreset_flags", flags_q, 4'b0000);
        check("midreset_out_result", out_result, 32'd0);
        check("midreset_out_rd", out_rd, 4'd0);

        // Randomized run against the queue model.
        q.delete();
        mflags = 4'b0000;
        for (int k = 0; k < 400; k++) begin
            logic v, s, rw, ordy, acc, ex, pp;
            logic [31:0] r;
            logic [3:0] f, c, rd;
            v = ($urandom_range(0, 3) != 0);
            r = $urandom();
            f = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'($urandom_range(0, 15));
            s = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            rd = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 2) != 0);
            acc = v && (q.size() < 2);
            ex = m_pass(c, mflags);
            pp = (q.size() > 0) && ordy;
            cycle(v, r, f, c, s, rw, rd, ordy);
            if (pp) void'(q.pop_front());
            if (acc && (ex || !DROP)) q.push_back('{r, rd, rw && ex, ex});
            if (acc && ex && s) mflags = f;
            check("rnd_flags", flags_q, mflags);
            check("rnd_in_ready", in_ready, q.size() < 2);
            check("rnd_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) begin
                check("rnd_result", out_result, q[0].result);
                check("rnd_rd", out_rd, q[0].rd);
                check("rnd_reg_write", out_reg_write, q[0].rw);
                check("rnd_executed", out_executed, q[0].ex);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
